// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_AUIPC    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_ALUWB    = 4'd11,
    S_BRANCH   = 4'd12
  } state_t;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALU source B select
  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags flow in,
// mux selects / strobes / ALU control flow out.
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] Flags;

  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] alucontrol;
  logic       LoadType;
  logic       StoreType;
  logic       PCTargetSrc;
  logic       illegal_instr;
  logic       instr_retire;

  // Controller side
  modport master (
    input  op, funct3, funct7b5, Flags,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
           RegWrite, MemWrite, alucontrol, LoadType, StoreType, PCTargetSrc,
           illegal_instr, instr_retire
  );

  // Datapath side
  modport slave (
    output op, funct3, funct7b5, Flags,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
           RegWrite, MemWrite, alucontrol, LoadType, StoreType, PCTargetSrc,
           illegal_instr, instr_retire
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder. Non-ALU instructions (including lui, whose funct3
// field is immediate bits) always get ADD.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_alu_op,
  output logic [3:0] alucontrol
);

  // funct3 picks the operation; funct7b5 only matters for R-type add/sub and shifts right
  always_comb begin
    alucontrol = ALU_ADD;
    if (is_alu_op) begin
      case (funct3)
        3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alucontrol = ALU_SLL;
        3'b010:  alucontrol = ALU_SLT;
        3'b011:  alucontrol = ALU_SLTU;
        3'b100:  alucontrol = ALU_XOR;
        3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alucontrol = ALU_OR;
        default: alucontrol = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM. Moore-style step controls per state; the
// branch PCWrite and the ALU operation in the execute states are decoded
// combinationally from the live instruction fields.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_controller_if.master bus,
  output logic [STATE_W-1:0]   state_dbg
);

  state_t     state_q;
  state_t     state_d;
  state_t     cur_s;
  logic       is_alu_op;
  logic [3:0] alu_dec;
  logic       op_known;

  // Branch condition from {N,Z,C,V}; C=1 means no borrow
  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
    logic n, z, c, v;
    n = fl[3];
    z = fl[2];
    c = fl[1];
    v = fl[0];
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = !z;
      3'b100:  branch_taken = n ^ v;
      3'b101:  branch_taken = !(n ^ v);
      3'b110:  branch_taken = !c;
      3'b111:  branch_taken = c;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Immediate format from opcode
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          imm_src_of = IMM_S;
      OP_BRANCH:         imm_src_of = IMM_B;
      OP_JAL:            imm_src_of = IMM_J;
      OP_LUI, OP_AUIPC:  imm_src_of = IMM_U;
      default:           imm_src_of = IMM_I;
    endcase
  endfunction

  assign is_alu_op = (bus.op == OP_R) || (bus.op == OP_I);

  alu_decoder u_alu_decoder (
    .op5        (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .is_alu_op  (is_alu_op),
    .alucontrol (alu_dec)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and DECODE opcode classification
  always_comb begin
    state_d  = state_q;
    op_known = 1'b1;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I, OP_LUI:      state_d = S_EXECI;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d  = S_FETCH;
            op_known = 1'b0;
          end
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // While rst is high the outputs show FETCH encodings with strobes held low
  assign cur_s = rst ? S_FETCH : state_q;

  // Per-state datapath controls, then reset gating of every strobe and pulse
  always_comb begin
    bus.ImmSrc        = imm_src_of(bus.op);
    bus.ALUSrcA       = SRCA_PC;
    bus.ALUSrcB       = SRCB_WD;
    bus.ResultSrc     = RES_ALUOUT;
    bus.AdrSrc        = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.alucontrol    = ALU_ADD;
    bus.LoadType      = 1'b0;
    bus.StoreType     = 1'b0;
    bus.PCTargetSrc   = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.instr_retire  = 1'b0;
    case (cur_s)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.PCWrite   = 1'b1;
      end
      S_DECODE: begin
        bus.ALUSrcA       = SRCA_OLDPC;
        bus.ALUSrcB       = SRCB_IMM;
        bus.illegal_instr = !op_known;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_A;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        bus.AdrSrc   = 1'b1;
        bus.LoadType = !bus.funct3[1];
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        bus.LoadType  = !bus.funct3[1];
      end
      S_MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.StoreType = (bus.funct3 == 3'b000);
      end
      S_EXECR: begin
        bus.ALUSrcA    = SRCA_A;
        bus.ALUSrcB    = SRCB_WD;
        bus.alucontrol = alu_dec;
      end
      S_EXECI: begin
        bus.ALUSrcA    = SRCA_A;
        bus.ALUSrcB    = SRCB_IMM;
        bus.alucontrol = alu_dec;
      end
      S_AUIPC: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_JALR: begin
        bus.ALUSrcA = SRCA_A;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = SRCA_A;
        bus.ALUSrcB    = SRCB_WD;
        bus.alucontrol = ALU_SUB;
        bus.PCWrite    = branch_taken(bus.funct3, bus.Flags);
      end
      default: ;
    endcase
    bus.instr_retire = (state_q != S_FETCH) && (state_d == S_FETCH);
    if (rst) begin
      bus.IRWrite       = 1'b0;
      bus.PCWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.illegal_instr = 1'b0;
      bus.instr_retire  = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state_q);

endmodule
